// File: rtl/text_console_writer_pkg.sv
// Shared constants, control codes and state encoding for the character-RAM console writer.
package text_console_writer_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 60;
  localparam int ADDR_W = 13;

  localparam logic [6:0] CH_BS    = 7'h08;
  localparam logic [6:0] CH_LF    = 7'h0A;
  localparam logic [6:0] CH_FF    = 7'h0C;
  localparam logic [6:0] CH_CR    = 7'h0D;
  localparam logic [6:0] CH_SPACE = 7'h20;

  typedef enum logic [1:0] {
    ST_CLEAR_ALL = 2'd0,
    ST_CLEAR_ROW = 2'd1,
    ST_IDLE      = 2'd2
  } state_e;

  function automatic logic is_printable(input logic [6:0] c);
    return (c >= 7'h20) && (c <= 7'h7E);
  endfunction

endpackage

// File: rtl/text_console_writer.sv
// Console writer: consumes a valid/ready ASCII stream and issues single-cycle writes to the
// character RAM write port, tracking a cursor and handling CR, LF, BS, FF, wrap and clears.
//
// state        | meaning
// ST_CLEAR_ALL | writing spaces over every cell, one per cycle
// ST_CLEAR_ROW | writing spaces over the cursor row, one per cycle
// ST_IDLE      | ready to accept a code
module text_console_writer #(
  parameter int COLS   = text_console_writer_pkg::COLS,
  parameter int ROWS   = text_console_writer_pkg::ROWS,
  parameter int ADDR_W = text_console_writer_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              charValid,
  input  logic [6:0]        charData,
  output logic              charReady,
  output logic              charRamWrEn,
  output logic [ADDR_W-1:0] charRamAddr,
  output logic [6:0]        charRamData,
  output logic [6:0]        cursorCol,
  output logic [5:0]        cursorRow,
  output logic              busy
);
  import text_console_writer_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_CELL    = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_CLR_COL = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP     = ADDR_W'(COLS);
  localparam logic [6:0]        LAST_COL     = 7'(COLS - 1);
  localparam logic [5:0]        LAST_ROW     = 6'(ROWS - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] clr_q;
  logic [ADDR_W-1:0] row_base_q;
  logic [ADDR_W-1:0] addr_q;
  logic [6:0]        data_q;
  logic              wr_en_q;
  logic [6:0]        col_q;
  logic [5:0]        row_q;

  logic [ADDR_W-1:0] cur_addr;
  logic [5:0]        nl_row_d;
  logic [ADDR_W-1:0] nl_base_d;

  // Row and row base after a newline; both wrap together so no multiply is ever needed.
  always_comb begin
    cur_addr  = row_base_q + ADDR_W'(col_q);
    nl_row_d  = row_q + 6'd1;
    nl_base_d = row_base_q + ROW_STEP;
    if (row_q == LAST_ROW) begin
      nl_row_d  = '0;
      nl_base_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CLEAR_ALL;
      clr_q      <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wr_en_q    <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        ST_CLEAR_ALL: begin
          wr_en_q <= 1'b1;
          addr_q  <= clr_q;
          data_q  <= CH_SPACE;
          if (clr_q == LAST_CELL) begin
            clr_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            clr_q <= clr_q + 1'b1;
          end
        end
        ST_CLEAR_ROW: begin
          wr_en_q <= 1'b1;
          addr_q  <= row_base_q + clr_q;
          data_q  <= CH_SPACE;
          if (clr_q == LAST_CLR_COL) begin
            clr_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            clr_q <= clr_q + 1'b1;
          end
        end
        ST_IDLE: begin
          if (charValid) begin
            if (is_printable(charData)) begin
              wr_en_q <= 1'b1;
              addr_q  <= cur_addr;
              data_q  <= charData;
              if (col_q == LAST_COL) begin
                col_q      <= '0;
                row_q      <= nl_row_d;
                row_base_q <= nl_base_d;
                clr_q      <= '0;
                state_q    <= ST_CLEAR_ROW;
              end else begin
                col_q <= col_q + 7'd1;
              end
            end else if (charData == CH_LF) begin
              col_q      <= '0;
              row_q      <= nl_row_d;
              row_base_q <= nl_base_d;
              clr_q      <= '0;
              state_q    <= ST_CLEAR_ROW;
            end else if (charData == CH_CR) begin
              col_q <= '0;
            end else if (charData == CH_BS) begin
              if (col_q != 7'd0) begin
                col_q   <= col_q - 7'd1;
                wr_en_q <= 1'b1;
                addr_q  <= cur_addr - 1'b1;
                data_q  <= CH_SPACE;
              end
            end else if (charData == CH_FF) begin
              col_q      <= '0;
              row_q      <= '0;
              row_base_q <= '0;
              clr_q      <= '0;
              state_q    <= ST_CLEAR_ALL;
            end
          end
        end
        default: begin
          clr_q   <= '0;
          state_q <= ST_CLEAR_ALL;
        end
      endcase
    end
  end

  assign charReady   = (state_q == ST_IDLE);
  assign busy        = ~charReady;
  assign charRamWrEn = wr_en_q;
  assign charRamAddr = addr_q;
  assign charRamData = data_q;
  assign cursorCol   = col_q;
  assign cursorRow   = row_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: a queue-of-expected-writes screen model checked every cycle,
// directed scenarios with hand-computed expectations, then randomized code streams.
module tb_text_console_writer;

  localparam int NC = 80;
  localparam int NR = 60;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        charValid = 1'b0;
  logic [6:0]  charData = 7'h00;
  logic        charReady, charRamWrEn, busy;
  logic [12:0] charRamAddr;
  logic [6:0]  charRamData;
  logic [6:0]  cursorCol;
  logic [5:0]  cursorRow;

  text_console_writer dut (
    .clk(clk), .reset(reset), .charValid(charValid), .charData(charData),
    .charReady(charReady), .charRamWrEn(charRamWrEn), .charRamAddr(charRamAddr),
    .charRamData(charRamData), .cursorCol(cursorCol), .cursorRow(cursorRow), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each accepted code expands into the list of per-cycle RAM-port events it must cause;
  // one event is consumed per clock, and the block is ready exactly when the list is empty.
  typedef struct packed {
    logic        we;
    logic [12:0] a;
    logic [6:0]  d;
  } ev_t;

  ev_t q[$];
  int  m_col, m_row;
  int  exp_wr, exp_addr, exp_data;

  task automatic push_clear(input int base, input int n);
    for (int i = 0; i < n; i++) q.push_back('{1'b1, 13'(base + i), 7'h20});
  endtask

  task automatic newline(input bit bubble);
    m_col = 0;
    m_row = (m_row + 1) % NR;
    if (bubble) q.push_back('{1'b0, 13'd0, 7'd0});
    push_clear(m_row * NC, NC);
  endtask

  task automatic model_accept(input int c);
    if (c >= 32 && c <= 126) begin
      q.push_back('{1'b1, 13'(m_row * NC + m_col), 7'(c)});
      if (m_col < NC - 1) m_col++;
      else newline(1'b0);
    end else if (c == 8'h0A) begin
      newline(1'b1);
    end else if (c == 8'h0D) begin
      m_col = 0;
    end else if (c == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        q.push_back('{1'b1, 13'(m_row * NC + m_col), 7'h20});
      end
    end else if (c == 8'h0C) begin
      m_col = 0;
      m_row = 0;
      q.push_back('{1'b0, 13'd0, 7'd0});
      push_clear(0, NC * NR);
    end
  endtask

  initial forever begin
    ev_t e;
    @(posedge clk or posedge reset);
    if (reset) begin
      q.delete();
      m_col = 0; m_row = 0;
      exp_wr = 0; exp_addr = 0; exp_data = 0;
      push_clear(0, NC * NR);
    end else begin
      if (charValid && q.size() == 0) model_accept(int'(charData));
      if (q.size() > 0) begin
        e = q.pop_front();
        exp_wr = int'(e.we);
        if (e.we) begin
          exp_addr = int'(e.a);
          exp_data = int'(e.d);
        end
      end else begin
        exp_wr = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int strobe_cnt = 0, busy_cnt = 0, last_addr = -1, last_data = -1;

  initial forever begin
    @(posedge clk);
    #1;
    if (!reset) begin
      chk("wr_en", int'(charRamWrEn), exp_wr);
      chk("addr", int'(charRamAddr), exp_addr);
      chk("data", int'(charRamData), exp_data);
      chk("ready", int'(charReady), (q.size() == 0) ? 1 : 0);
      chk("busy", int'(busy), (q.size() == 0) ? 0 : 1);
      chk("col", int'(cursorCol), m_col);
      chk("row", int'(cursorRow), m_row);
      if (charRamWrEn) begin
        strobe_cnt++;
        last_addr = int'(charRamAddr);
        last_data = int'(charRamData);
      end
      if (!charReady) busy_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for charReady, got 0 expected 1", name);
  endtask

  task automatic send(input logic [6:0] c);
    int n = 0;
    @(negedge clk);
    charValid = 1'b1;
    charData  = c;
    while (!charReady && n < 10000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10000) timeout("send");
    @(negedge clk);
    charValid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!charReady && n < 10000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10000) timeout("wait_idle");
  endtask

  function automatic logic [6:0] rand_code();
    int r = $urandom_range(0, 127);
    int o;
    if (r == 0) return 7'h0C;
    if (r < 14) return 7'h0A;
    if (r < 26) return 7'h0D;
    if (r < 38) return 7'h08;
    if (r < 44) begin
      o = $urandom_range(0, 31);
      if (o == 8 || o == 10 || o == 12 || o == 13) o = 127;
      return 7'(o);
    end
    return 7'($urandom_range(32, 126));
  endfunction

  initial begin
    int s, b;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", int'(charRamWrEn), 0);
    chk("rst_addr", int'(charRamAddr), 0);
    chk("rst_data", int'(charRamData), 0);
    chk("rst_ready", int'(charReady), 0);
    chk("rst_cursor", int'({cursorRow, cursorCol}), 0);
    reset = 1'b0;

    wait_idle();
    chk("init_strobes", strobe_cnt, 4800);
    chk("init_last_addr", last_addr, 4799);

    send(7'h41);
    chk("A_addr", last_addr, 0);
    chk("A_data", last_data, 8'h41);
    chk("A_col", int'(cursorCol), 1);

    s = strobe_cnt; b = busy_cnt;
    for (int i = 0; i < 79; i++) send(7'($urandom_range(32, 126)));
    wait_idle();
    chk("row0_strobes", strobe_cnt - s, 159);
    chk("row0_last_addr", last_addr, 159);
    chk("row0_busy_cycles", busy_cnt - b, 80);
    chk("row0_cursor", int'(cursorRow) * 100 + int'(cursorCol), 100);

    s = strobe_cnt;
    send(7'h08);
    chk("bs_col0_strobes", strobe_cnt - s, 0);
    send(7'h41); send(7'h42); send(7'h43); send(7'h08);
    chk("bs_addr", last_addr, 82);
    chk("bs_data", last_data, 8'h20);
    chk("bs_col", int'(cursorCol), 2);

    send(7'h0D);
    chk("cr_col", int'(cursorCol), 0);

    for (int i = 0; i < 58; i++) send(7'h0A);
    wait_idle();
    chk("row59", int'(cursorRow), 59);
    s = strobe_cnt;
    send(7'h0A);
    wait_idle();
    chk("wrap_cursor", int'({cursorRow, cursorCol}), 0);
    chk("wrap_strobes", strobe_cnt - s, 80);
    chk("wrap_last_addr", last_addr, 79);

    for (int i = 0; i < 10; i++) send(7'h0A);
    for (int i = 0; i < 5; i++) send(7'h78);
    chk("ff_pre_pos", int'(cursorRow) * 100 + int'(cursorCol), 1005);
    s = strobe_cnt;
    send(7'h0C);
    wait_idle();
    chk("ff_strobes", strobe_cnt - s, 4800);
    chk("ff_last_addr", last_addr, 4799);
    chk("ff_cursor", int'({cursorRow, cursorCol}), 0);

    // 'Z' is presented while the row clear is still running and must wait for it.
    s = strobe_cnt;
    send(7'h0A);
    send(7'h5A);
    chk("held_strobes", strobe_cnt - s, 81);
    chk("held_addr", last_addr, 80);
    chk("held_data", last_data, 8'h5A);

    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(rand_code());
    end
    wait_idle();

    send(7'h0C);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_wr_en", int'(charRamWrEn), 0);
    chk("midrst_ready", int'(charReady), 0);
    chk("midrst_cursor", int'({cursorRow, cursorCol}), 0);
    @(negedge clk);
    reset = 1'b0;
    s = strobe_cnt;
    wait_idle();
    chk("midrst_strobes", strobe_cnt - s, 4800);
    chk("midrst_last_addr", last_addr, 4799);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
